fifo_rd_ctrl: RTL and testbench

Read-side controller for the 8-entry x 32-bit register-file FIFO. It consumes words produced by the write-side controller. It owns the read pointer and the occupancy count, drives the register-file read address, and returns data with an ack/error handshake. It sits between the FIFO storage and the downstream consumer. A one-cycle write-done pulse from the write controller is its only link to the write side.

---
 rtl/fifo_rd_ctrl.sv | 105 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side controller for the register-file FIFO (optional FIFO_RD_ERR_CNT_EN)
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_en,
    input  logic                  wr_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   data_count
`ifdef FIFO_RD_ERR_CNT_EN
    ,
    output logic [7:0]            rd_err_cnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        NO_OP    = 2'd1,
        READ     = 2'd2,
        RD_ERROR = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  accept;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; INIT always falls through to NO_OP, ignoring rd_en
    always_comb begin
        next_state = NO_OP;
        if (state != INIT) begin
            if (rd_en && (data_count != '0)) begin
                next_state = READ;
            end else if (rd_en) begin
                next_state = RD_ERROR;
            end else begin
                next_state = NO_OP;
            end
        end
    end

    assign accept = (next_state == READ);

    // Read pointer and output data capture on each accepted read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            dout   <= '0;
        end else if (accept) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            dout   <= mem_rdata;
        end
    end

    // Occupancy: +1 per stored word, -1 per accepted read, saturating at full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_count <= '0;
        end else if (wr_done && !accept) begin
            if (data_count != FULL_CNT) begin
                data_count <= data_count + (ADDR_WIDTH + 1)'(1);
            end
        end else if (accept && !wr_done) begin
            data_count <= data_count - (ADDR_WIDTH + 1)'(1);
        end
    end

`ifdef FIFO_RD_ERR_CNT_EN
    // Saturating count of reads attempted while empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_err_cnt <= '0;
        end else if ((next_state == RD_ERROR) && (rd_err_cnt != 8'hFF)) begin
            rd_err_cnt <= rd_err_cnt + 8'd1;
        end
    end
`endif

    assign mem_raddr = rd_ptr;
    assign rd_ack    = (state == READ);
    assign rd_err    = (state == RD_ERROR);
    assign empty     = (data_count == '0);
    assign full      = (data_count == FULL_CNT);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_done = 1'b0;
    logic [31:0] mem_rdata;
    logic [2:0]  mem_raddr;
    logic [31:0] dout;
    logic        rd_ack;
    logic        rd_err;
    logic        empty;
    logic        full;
    logic [3:0]  data_count;
`ifdef FIFO_RD_ERR_CNT_EN
    logic [7:0]  rd_err_cnt;
`endif

    logic [31:0] mem [8];
    logic [2:0]  wp = 3'd0;
    int          checks = 0;
    int          failures = 0;

    assign mem_rdata = mem[mem_raddr];

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_en      (rd_en),
        .wr_done    (wr_done),
        .mem_rdata  (mem_rdata),
        .mem_raddr  (mem_raddr),
        .dout       (dout),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .empty      (empty),
        .full       (full),
        .data_count (data_count)
`ifdef FIFO_RD_ERR_CNT_EN
        ,
        .rd_err_cnt (rd_err_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rd_en   = 1'b0;
        wr_done = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wp      = 3'd0;
        tick();
    endtask

    task automatic push(input logic [31:0] d);
        mem[wp] = d;
        wp      = wp + 3'd1;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        reset_n = 1'b0;
        tick();
        checks++;
        if (dout !== 32'h0 || empty !== 1'b1 || full !== 1'b0 || data_count !== 4'd0 ||
            rd_ack !== 1'b0 || rd_err !== 1'b0 || mem_raddr !== 3'd0) begin
            failures++;
            $display("FAIL reset_values dout=%h empty=%b full=%b cnt=%0d ack=%b err=%b raddr=%0d required 0,1,0,0,0,0,0",
                     dout, empty, full, data_count, rd_ack, rd_err, mem_raddr);
        end
        reset_n = 1'b1;
        // first edge after release: still INIT, rd_en ignored, wr_done counted
        mem[0]  = 32'h5A;
        wp      = 3'd1;
        rd_en   = 1'b1;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        checks++;
        if (rd_ack !== 1'b0 || rd_err !== 1'b0 || data_count !== 4'd1) begin
            failures++;
            $display("FAIL init_exit ack=%b err=%b cnt=%0d required 0,0,1", rd_ack, rd_err, data_count);
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_ack !== 1'b1 || dout !== 32'h5A || data_count !== 4'd0) begin
            failures++;
            $display("FAIL init_first_read ack=%b dout=%h cnt=%0d required 1,5a,0", rd_ack, dout, data_count);
        end
        tick();
        checks++;
        if (rd_ack !== 1'b0 || dout !== 32'h5A) begin
            failures++;
            $display("FAIL noop_hold ack=%b dout=%h required 0,5a", rd_ack, dout);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
        do_reset();
        push(32'h11);
        push(32'h22);
        push(32'h33);
        checks++;
        if (data_count !== 4'd3 || empty !== 1'b0) begin
            failures++;
            $display("FAIL b2b_fill cnt=%0d empty=%b required 3,0", data_count, empty);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd_ack !== 1'b1 || rd_err !== 1'b0 || dout !== exp_d[i] || data_count !== 4'(2 - i)) begin
                failures++;
                $display("FAIL b2b_read%0d ack=%b err=%b dout=%h cnt=%0d required 1,0,%h,%0d",
                         i, rd_ack, rd_err, dout, data_count, exp_d[i], 2 - i);
            end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty empty=%b required 1", empty);
        end
    endtask

    task automatic test_rd_err();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_err !== 1'b1 || rd_ack !== 1'b0 || dout !== 32'h33 || data_count !== 4'd0) begin
            failures++;
            $display("FAIL rd_err_pulse err=%b ack=%b dout=%h cnt=%0d required 1,0,33,0", rd_err, rd_ack, dout, data_count);
        end
`ifdef FIFO_RD_ERR_CNT_EN
        checks++;
        if (rd_err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rd_err_cnt got=%0d required 1", rd_err_cnt);
        end
`endif
        tick();
        checks++;
        if (rd_err !== 1'b0 || mem_raddr !== 3'd3) begin
            failures++;
            $display("FAIL rd_err_clear err=%b raddr=%0d required 0,3", rd_err, mem_raddr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        checks++;
        if (full !== 1'b1 || data_count !== 4'd8) begin
            failures++;
            $display("FAIL wrap_full full=%b cnt=%0d required 1,8", full, data_count);
        end
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        checks++;
        if (data_count !== 4'd8 || full !== 1'b1) begin
            failures++;
            $display("FAIL wrap_saturate cnt=%0d full=%b required 8,1", data_count, full);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_raddr !== 3'(i)) begin
                failures++;
                $display("FAIL wrap_raddr%0d got=%0d required %0d", i, mem_raddr, i);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            checks++;
            if (dout !== 32'hA0 + i || data_count !== 4'(7 - i)) begin
                failures++;
                $display("FAIL wrap_read%0d dout=%h cnt=%0d required %h,%0d", i, dout, data_count, 32'hA0 + i, 7 - i);
            end
        end
        push(32'hB0);
        push(32'hB1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_raddr !== 3'(i)) begin
                failures++;
                $display("FAIL wrap2_raddr%0d got=%0d required %0d", i, mem_raddr, i);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            checks++;
            if (dout !== 32'hB0 + i || data_count !== 4'(1 - i)) begin
                failures++;
                $display("FAIL wrap2_read%0d dout=%h cnt=%0d required %h,%0d", i, dout, data_count, 32'hB0 + i, 1 - i);
            end
        end
    endtask

    task automatic test_simultaneous();
        push(32'hC1);
        mem[wp] = 32'hC2;
        wp      = wp + 3'd1;
        wr_done = 1'b1;
        rd_en   = 1'b1;
        tick();
        wr_done = 1'b0;
        checks++;
        if (rd_ack !== 1'b1 || dout !== 32'hC1 || data_count !== 4'd1) begin
            failures++;
            $display("FAIL simul_cnt1 ack=%b dout=%h cnt=%0d required 1,c1,1", rd_ack, dout, data_count);
        end
        tick();
        checks++;
        if (dout !== 32'hC2 || data_count !== 4'd0) begin
            failures++;
            $display("FAIL simul_drain dout=%h cnt=%0d required c2,0", dout, data_count);
        end
        mem[wp] = 32'hC3;
        wp      = wp + 3'd1;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        checks++;
        if (rd_err !== 1'b1 || rd_ack !== 1'b0 || dout !== 32'hC2 || data_count !== 4'd1) begin
            failures++;
            $display("FAIL simul_cnt0 err=%b ack=%b dout=%h cnt=%0d required 1,0,c2,1", rd_err, rd_ack, dout, data_count);
        end
`ifdef FIFO_RD_ERR_CNT_EN
        checks++;
        if (rd_err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL simul_err_cnt got=%0d required 1", rd_err_cnt);
        end
`endif
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_ack !== 1'b1 || rd_err !== 1'b0 || dout !== 32'hC3 || data_count !== 4'd0) begin
            failures++;
            $display("FAIL simul_after ack=%b err=%b dout=%h cnt=%0d required 1,0,c3,0", rd_ack, rd_err, dout, data_count);
        end
    endtask

    task automatic test_reset_mid_read();
        push(32'hD0);
        push(32'hD1);
        push(32'hD2);
        push(32'hD3);
        rd_en = 1'b1;
        tick();
        tick();
        checks++;
        if (dout !== 32'hD1 || data_count !== 4'd2) begin
            failures++;
            $display("FAIL mid_burst dout=%h cnt=%0d required d1,2", dout, data_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dout !== 32'h0 || rd_ack !== 1'b0 || data_count !== 4'd0 || empty !== 1'b1 || mem_raddr !== 3'd0) begin
            failures++;
            $display("FAIL async_reset dout=%h ack=%b cnt=%0d empty=%b raddr=%0d required 0,0,0,1,0",
                     dout, rd_ack, data_count, empty, mem_raddr);
        end
        rd_en = 1'b0;
        tick();
        reset_n = 1'b1;
        wp      = 3'd0;
        tick();
        checks++;
        if (mem_raddr !== 3'd0 || data_count !== 4'd0 || rd_ack !== 1'b0) begin
            failures++;
            $display("FAIL post_reset raddr=%0d cnt=%0d ack=%b required 0,0,0", mem_raddr, data_count, rd_ack);
        end
        push(32'hE0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (dout !== 32'hE0 || rd_ack !== 1'b1 || mem_raddr !== 3'd1) begin
            failures++;
            $display("FAIL post_reset_read dout=%h ack=%b raddr=%0d required e0,1,1", dout, rd_ack, mem_raddr);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rd_err();
        test_wrap();
        test_simultaneous();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
